// File: rtl/truth_table_sweeper_if.sv
// Handshake and result bundle between a sweep host (master) and truth_table_sweeper (slave).
// The host also returns the function-under-test output on dut_f.
interface truth_table_sweeper_if #(
  parameter int N_IN  = 4,
  parameter int ERR_W = N_IN + 1
);
  logic                 start;
  logic                 abort;
  logic [2**N_IN-1:0]   expected;
  logic                 dut_f;
  logic [N_IN-1:0]      sweep_vec;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [ERR_W-1:0]     err_count;
  logic [N_IN-1:0]      first_fail;
  logic                 first_fail_valid;

  modport master (
    output start, abort, expected, dut_f,
    input  sweep_vec, busy, done, pass, err_count, first_fail, first_fail_valid
  );

  modport slave (
    input  start, abort, expected, dut_f,
    output sweep_vec, busy, done, pass, err_count, first_fail, first_fail_valid
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweep engine: walks every input vector, holds it SETTLE cycles,
// and checks the sampled function output against a truth table latched at start.
module truth_table_sweeper #(
  parameter int N_IN         = 4,
  parameter int SETTLE       = 1,
  parameter int ERR_W        = N_IN + 1,
  parameter int STOP_ON_FAIL = 0
) (
  input logic                  clk,
  input logic                  rst,
  truth_table_sweeper_if.slave bus
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [2**N_IN-1:0] exp_lat;
  logic [CNT_W-1:0]   settle_cnt;
  logic [N_IN-1:0]    sweep_vec;
  logic               busy;
  logic               done;
  logic               pass;
  logic [ERR_W-1:0]   err_count;
  logic [N_IN-1:0]    first_fail;
  logic               first_fail_valid;

  logic               sample;
  logic               mism;
  logic               finish;
  logic [ERR_W-1:0]   err_upd;

  // Sample-edge decode; the compare only ever reads the latched table.
  always_comb begin
    sample  = (state == RUN) && (settle_cnt == CNT_W'(SETTLE - 1));
    mism    = bus.dut_f ^ exp_lat[sweep_vec];
    err_upd = err_count;
    if (mism && (err_count != {ERR_W{1'b1}}))
      err_upd = err_count + ERR_W'(1);
    finish  = (sweep_vec == {N_IN{1'b1}}) || ((STOP_ON_FAIL != 0) && mism);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      exp_lat          <= '0;
      settle_cnt       <= '0;
      sweep_vec        <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= '0;
      first_fail       <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            exp_lat          <= bus.expected;
            sweep_vec        <= '0;
            settle_cnt       <= '0;
            err_count        <= '0;
            first_fail       <= '0;
            first_fail_valid <= 1'b0;
            pass             <= 1'b0;
            done             <= 1'b0;
            busy             <= 1'b1;
            state            <= RUN;
          end
        end
        RUN: begin
          // Abort discards any sample due on this edge but keeps partial results.
          if (bus.abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            pass  <= 1'b0;
          end else if (sample) begin
            err_count <= err_upd;
            if (mism && !first_fail_valid) begin
              first_fail       <= sweep_vec;
              first_fail_valid <= 1'b1;
            end
            if (finish) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_upd == '0);
            end else begin
              sweep_vec  <= sweep_vec + N_IN'(1);
              settle_cnt <= '0;
            end
          end else begin
            settle_cnt <= settle_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sweep_vec        = sweep_vec;
  assign bus.busy             = busy;
  assign bus.done             = done;
  assign bus.pass             = pass;
  assign bus.err_count        = err_count;
  assign bus.first_fail       = first_fail;
  assign bus.first_fail_valid = first_fail_valid;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: three instances cover SETTLE=1, STOP_ON_FAIL=1
// and SETTLE=3; the function under test is XNOR(bit0, bit2) with optional inverted vectors.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [15:0] mask0 = '0;
  logic [15:0] mask1 = '0;
  logic [15:0] mask2 = '0;

  always #5 clk = ~clk;

  truth_table_sweeper_if #(.N_IN(4)) bus0 ();
  truth_table_sweeper_if #(.N_IN(4)) bus1 ();
  truth_table_sweeper_if #(.N_IN(4)) bus2 ();

  // Golden function is XNOR of vector bits 0 and 2; mask bits invert F at chosen vectors.
  assign bus0.dut_f = ~(bus0.sweep_vec[0] ^ bus0.sweep_vec[2]) ^ mask0[bus0.sweep_vec];
  assign bus1.dut_f = ~(bus1.sweep_vec[0] ^ bus1.sweep_vec[2]) ^ mask1[bus1.sweep_vec];
  assign bus2.dut_f = ~(bus2.sweep_vec[0] ^ bus2.sweep_vec[2]) ^ mask2[bus2.sweep_vec];

  truth_table_sweeper #(.N_IN(4), .SETTLE(1), .STOP_ON_FAIL(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  truth_table_sweeper #(.N_IN(4), .SETTLE(1), .STOP_ON_FAIL(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  truth_table_sweeper #(.N_IN(4), .SETTLE(3), .STOP_ON_FAIL(0)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    bus0.start = 0; bus0.abort = 0; bus0.expected = 16'hA5A5;
    bus1.start = 0; bus1.abort = 0; bus1.expected = 16'hA5A5;
    bus2.start = 0; bus2.abort = 0; bus2.expected = 16'hA5A5;

    // Power-on reset
    applyStimulus(2);
    rst = 0;
    checkOutput("rst_busy", bus0.busy, 0);
    checkOutput("rst_done", bus0.done, 0);
    checkOutput("rst_pass", bus0.pass, 0);
    checkOutput("rst_err", bus0.err_count, 0);
    checkOutput("rst_ff", bus0.first_fail, 0);
    checkOutput("rst_ffv", bus0.first_fail_valid, 0);
    checkOutput("rst_vec", bus0.sweep_vec, 0);
    checkOutput("rst_busy1", bus1.busy, 0);
    checkOutput("rst_done2", bus2.done, 0);

    // Golden sweep, one vector per cycle
    bus0.start = 1;
    applyStimulus(1);
    bus0.start = 0;
    checkOutput("gold_busy0", bus0.busy, 1);
    checkOutput("gold_vec0", bus0.sweep_vec, 0);
    for (int k = 1; k < 16; k++) begin
      applyStimulus(1);
      checkOutput("gold_vec", bus0.sweep_vec, k);
      checkOutput("gold_notdone", bus0.done, 0);
    end
    applyStimulus(1);
    checkOutput("gold_done", bus0.done, 1);
    checkOutput("gold_busy", bus0.busy, 0);
    checkOutput("gold_pass", bus0.pass, 1);
    checkOutput("gold_err", bus0.err_count, 0);
    checkOutput("gold_ffv", bus0.first_fail_valid, 0);
    checkOutput("gold_vec_hold", bus0.sweep_vec, 15);

    // Faulty model: F inverted at vectors 5 and 12
    mask0 = 16'h1020;
    bus0.start = 1;
    applyStimulus(1);
    bus0.start = 0;
    checkOutput("flt_cleared", bus0.done, 0);
    applyStimulus(15);
    checkOutput("flt_notdone15", bus0.done, 0);
    applyStimulus(1);
    checkOutput("flt_done", bus0.done, 1);
    checkOutput("flt_err", bus0.err_count, 2);
    checkOutput("flt_ff", bus0.first_fail, 5);
    checkOutput("flt_ffv", bus0.first_fail_valid, 1);
    checkOutput("flt_pass", bus0.pass, 0);

    // Reset held two cycles mid-run at vector 6
    mask0 = 16'h0000;
    bus0.start = 1;
    applyStimulus(1);
    bus0.start = 0;
    applyStimulus(6);
    checkOutput("mrst_vec6", bus0.sweep_vec, 6);
    rst = 1;
    applyStimulus(1);
    checkOutput("mrst_busy", bus0.busy, 0);
    checkOutput("mrst_vec", bus0.sweep_vec, 0);
    checkOutput("mrst_done", bus0.done, 0);
    checkOutput("mrst_err", bus0.err_count, 0);
    applyStimulus(1);
    rst = 0;
    bus0.start = 1;
    applyStimulus(1);
    bus0.start = 0;
    checkOutput("mrst_restart_vec", bus0.sweep_vec, 0);
    checkOutput("mrst_restart_busy", bus0.busy, 1);
    applyStimulus(16);
    checkOutput("mrst_restart_done", bus0.done, 1);
    checkOutput("mrst_restart_pass", bus0.pass, 1);

    // Abort on the sample edge of vector 7 (vectors 5 and 7 mismatch)
    mask0 = 16'h00A0;
    bus0.start = 1;
    applyStimulus(1);
    bus0.start = 0;
    applyStimulus(7);
    checkOutput("abt_vec7", bus0.sweep_vec, 7);
    checkOutput("abt_err_pre", bus0.err_count, 1);
    bus0.abort = 1;
    applyStimulus(1);
    bus0.abort = 0;
    checkOutput("abt_busy", bus0.busy, 0);
    checkOutput("abt_done", bus0.done, 0);
    checkOutput("abt_pass", bus0.pass, 0);
    checkOutput("abt_err_kept", bus0.err_count, 1);
    checkOutput("abt_ff_kept", bus0.first_fail, 5);
    checkOutput("abt_ffv_kept", bus0.first_fail_valid, 1);
    applyStimulus(1);
    checkOutput("abt_idle", bus0.busy, 0);

    // Complete a sweep, then start+abort together in DONE
    bus0.start = 1;
    applyStimulus(1);
    bus0.start = 0;
    applyStimulus(16);
    checkOutput("sa_done", bus0.done, 1);
    checkOutput("sa_err", bus0.err_count, 2);
    bus0.start = 1;
    bus0.abort = 1;
    applyStimulus(1);
    bus0.start = 0;
    bus0.abort = 0;
    checkOutput("sa_busy", bus0.busy, 1);
    checkOutput("sa_done_clr", bus0.done, 0);
    checkOutput("sa_err_clr", bus0.err_count, 0);
    checkOutput("sa_ffv_clr", bus0.first_fail_valid, 0);
    applyStimulus(16);
    checkOutput("sa_done2", bus0.done, 1);
    checkOutput("sa_err2", bus0.err_count, 2);

    // STOP_ON_FAIL with faults at 5 and 12
    mask1 = 16'h1020;
    bus1.start = 1;
    applyStimulus(1);
    bus1.start = 0;
    applyStimulus(5);
    checkOutput("sof_notdone", bus1.done, 0);
    applyStimulus(1);
    checkOutput("sof_done", bus1.done, 1);
    checkOutput("sof_busy", bus1.busy, 0);
    checkOutput("sof_vec", bus1.sweep_vec, 5);
    checkOutput("sof_err", bus1.err_count, 1);
    checkOutput("sof_ff", bus1.first_fail, 5);
    checkOutput("sof_pass", bus1.pass, 0);
    mask1 = 16'h0000;
    bus1.start = 1;
    applyStimulus(1);
    bus1.start = 0;
    applyStimulus(16);
    checkOutput("sof_gold_done", bus1.done, 1);
    checkOutput("sof_gold_pass", bus1.pass, 1);

    // SETTLE=3: ignored start while busy, expected changed after start edge
    bus2.start = 1;
    applyStimulus(1);
    bus2.start = 0;
    checkOutput("s3_vec0", bus2.sweep_vec, 0);
    applyStimulus(2);
    checkOutput("s3_hold0", bus2.sweep_vec, 0);
    applyStimulus(1);
    checkOutput("s3_vec1", bus2.sweep_vec, 1);
    applyStimulus(2);
    bus2.expected = 16'h0000;
    applyStimulus(5);
    bus2.start = 1;
    applyStimulus(1);
    bus2.start = 0;
    checkOutput("s3_ignored_start", bus2.sweep_vec, 3);
    checkOutput("s3_busy", bus2.busy, 1);
    applyStimulus(36);
    checkOutput("s3_vec15", bus2.sweep_vec, 15);
    checkOutput("s3_notdone47", bus2.done, 0);
    applyStimulus(1);
    checkOutput("s3_done48", bus2.done, 1);
    checkOutput("s3_pass", bus2.pass, 1);
    checkOutput("s3_err", bus2.err_count, 0);
    checkOutput("s3_busy_end", bus2.busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
